vote_ballot_collector: RTL and testbench
========================================

// Module: vote_ballot_collector
// PURPOSE
//  Front end that produces the 3-bit ballot consumed by the majority-vote logic.
//  Three voters each set a yes/no switch and press a cast button inside a timed voting window.
//  The block debounces all buttons, latches each voter's first cast and closes the window on all-cast or timeout.
//  It then presents ballot[2:0], yes count and majority result, held until the next session starts.
// PARAMETERS
//  DB_CYCLES      1000        consecutive stable cycles before a debounced button level changes (>=2)
//  DB_W           10          debounce counter width; must satisfy 2**DB_W > DB_CYCLES
//  WINDOW_CYCLES  50_000_000  voting window length in clk cycles (>=2)
//  WIN_W          26          window timer width; must satisfy 2**WIN_W > WINDOW_CYCLES
// PORTS
//  clk           in   1  system clock; all logic on rising edge
//  rst_n         in   1  synchronous, active-low reset
//  start_btn     in   1  raw start/new-session button, active high, asynchronous to clk
//  sw_in         in   3  raw voter switches, 1 = yes; bit i belongs to voter i
//  cast_btn      in   3  raw cast buttons, active high; bit i belongs to voter i
//  window_open   out  1  1 while state == OPEN
//  cast_led      out  3  bit i = 1 once voter i has cast in the current session
//  ballot        out  3  latched votes; uncast voters read 0 (no)
//  ballot_valid  out  1  1 in SHOW state; ballot, yes_count and agreement are final
//  yes_count     out  2  number of 1s in ballot (0..3)
//  agreement     out  1  1 when yes_count >= 2; valid only when ballot_valid = 1
//  result_pulse  out  1  one-cycle pulse on entry to SHOW
//  timeout       out  1  1 in SHOW if the window expired before all three voters cast
// BEHAVIOUR
//  Reset (rst_n = 0 at a clk edge): state IDLE, every output 0, timer 0, all sync/debounce regs 0.
//  Reset overrides any state, including mid-window and mid-debounce.
//  Input conditioning: every raw input passes through a 2-FF synchronizer.
//  Buttons: debounced level changes only after the synced value differs from it for DB_CYCLES consecutive cycles.
//  A glitch shorter than DB_CYCLES resets the count and causes no change.
//  Press event: one-cycle pulse on the debounced 0->1 edge.
//  Latency from raw press to press event: 2 + DB_CYCLES + 1 cycles.
//  sw_in is synchronized but not debounced; its value is sampled on the cycle of the cast press event.
//  FSM states: IDLE, OPEN, TALLY, SHOW.
//   IDLE : start press -> OPEN; clear cast_led and ballot; load timer = WINDOW_CYCLES-1.
//   OPEN : on cast press i with cast_led[i] = 0, set ballot[i] = synced sw_in[i] and cast_led[i] = 1.
//          Recast by a voter that has already cast is ignored; start press is ignored.
//          Timer decrements by 1 each cycle.
//          If all three have cast (including casts accepted this cycle): go to TALLY, timeout = 0.
//          Else if timer == 0: go to TALLY, timeout = 1.
//          A cast on the same cycle as timer == 0 is accepted. It still leads to timeout = 1
//          unless it completes the ballot (all-cast takes priority).
//   TALLY: one cycle. Register yes_count = popcount(ballot) and agreement = (yes_count >= 2).
//          Go to SHOW.
//   SHOW : ballot_valid = 1; result_pulse = 1 on the first SHOW cycle only.
//          Outputs held stable; cast presses ignored.
//          Start press -> OPEN: clear ballot, cast_led, yes_count, agreement, timeout and ballot_valid;
//          reload timer.
//  Simultaneous casts by several voters in one cycle are all accepted.
//  Latency from final accepted cast to result_pulse: 2 cycles (OPEN->TALLY->SHOW).
//  window_open and ballot_valid are never 1 together.
// TESTING (bench uses DB_CYCLES=4, WINDOW_CYCLES=100)
//  1. Reset held 3 cycles, then released -> all outputs 0, state IDLE.
//     Cast presses while in IDLE -> cast_led stays 000.
//  2. Start; sw_in=3'b101; cast all three at spaced times -> cast_led 001,011,111 as cast;
//     ballot=101, yes_count=2, agreement=1, timeout=0, result_pulse exactly 2 cycles after last cast.
//  3. Start; sw_in=3'b111; only voter 0 casts -> after 100 window cycles timeout=1,
//     ballot=001, yes_count=1, agreement=0.
//  4. Bounce test: 3-cycle pulses on cast_btn[1] -> no cast.
//     Voter 1 casts yes, then flips sw to 0 and recasts -> ballot[1] stays 1.
//  5. All three cast in the same cycle with sw_in=3'b011 -> single TALLY;
//     yes_count=2, agreement=1; start press during OPEN ignored.
//  6. rst_n low for 1 cycle mid-OPEN after two casts -> IDLE, outputs 0;
//     new start -> fresh window, cast_led=000.

Source files
------------

// File: rtl/vote_ballot_collector.sv
// rtl/vote_ballot_collector.sv - debounced three-voter ballot front end with timed voting window
module vote_ballot_collector #(
    parameter int DB_CYCLES     = 1000,
    parameter int DB_W          = 10,
    parameter int WINDOW_CYCLES = 50_000_000,
    parameter int WIN_W         = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic [2:0] sw_in,
    input  logic [2:0] cast_btn,
    output logic       window_open,
    output logic [2:0] cast_led,
    output logic [2:0] ballot,
    output logic       ballot_valid,
    output logic [1:0] yes_count,
    output logic       agreement,
    output logic       result_pulse,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, OPEN, TALLY, SHOW} state_t;

    state_t            state, state_n;
    logic [WIN_W-1:0]  timer, timer_n;
    logic [2:0]        cast_led_n, ballot_n, accept;
    logic [1:0]        yes_n;
    logic              agree_n, timeout_n;

    // Bit 3 is the start button, bits 2:0 are the cast buttons.
    logic [3:0]        btn_s1, btn_s2, db_level, db_prev, press;
    logic [DB_W-1:0]   db_cnt [4];
    logic [2:0]        sw_s1, sw_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            db_level <= '0;
            db_prev  <= '0;
            press    <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            btn_s1  <= {start_btn, cast_btn};
            btn_s2  <= btn_s1;
            sw_s1   <= sw_in;
            sw_s2   <= sw_s1;
            db_prev <= db_level;
            press   <= db_level & ~db_prev;
            // Level flips on the DB_CYCLES-th consecutive differing sample.
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                        db_level[i] <= btn_s2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        cast_led_n = cast_led;
        ballot_n   = ballot;
        yes_n      = yes_count;
        agree_n    = agreement;
        timeout_n  = timeout;
        accept     = '0;
        case (state)
            IDLE, SHOW: begin
                if (press[3]) begin
                    state_n    = OPEN;
                    timer_n    = WIN_W'(WINDOW_CYCLES - 1);
                    cast_led_n = '0;
                    ballot_n   = '0;
                    yes_n      = '0;
                    agree_n    = 1'b0;
                    timeout_n  = 1'b0;
                end
            end
            OPEN: begin
                accept     = press[2:0] & ~cast_led;
                cast_led_n = cast_led | accept;
                ballot_n   = (ballot & ~accept) | (sw_s2 & accept);
                // A completed ballot wins over an expiring timer on the same cycle.
                if (&cast_led_n) begin
                    state_n   = TALLY;
                    timeout_n = 1'b0;
                end else if (timer == '0) begin
                    state_n   = TALLY;
                    timeout_n = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            TALLY: begin
                yes_n   = {1'b0, ballot[0]} + {1'b0, ballot[1]} + {1'b0, ballot[2]};
                agree_n = (yes_n >= 2'd2);
                state_n = SHOW;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            cast_led     <= '0;
            ballot       <= '0;
            yes_count    <= '0;
            agreement    <= 1'b0;
            timeout      <= 1'b0;
            result_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            cast_led     <= cast_led_n;
            ballot       <= ballot_n;
            yes_count    <= yes_n;
            agreement    <= agree_n;
            timeout      <= timeout_n;
            result_pulse <= (state == TALLY);
        end
    end

    assign window_open  = (state == OPEN);
    assign ballot_valid = (state == SHOW);

endmodule

// File: tb/tb_vote_ballot_collector.sv
// tb/tb_vote_ballot_collector.sv - directed bench with session-level reference model for vote_ballot_collector
module tb_vote_ballot_collector;

    localparam int DB  = 4;
    localparam int WIN = 100;
    localparam int P_IDLE = 0, P_OPEN = 1, P_TALLY = 2, P_SHOW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic [2:0] sw_in = '0;
    logic [2:0] cast_btn = '0;
    logic       window_open, ballot_valid, agreement, result_pulse, timeout;
    logic [2:0] cast_led, ballot;
    logic [1:0] yes_count;

    int checks = 0;
    int errors = 0;

    vote_ballot_collector #(
        .DB_CYCLES(DB), .DB_W(3), .WINDOW_CYCLES(WIN), .WIN_W(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .sw_in(sw_in), .cast_btn(cast_btn),
        .window_open(window_open), .cast_led(cast_led), .ballot(ballot),
        .ballot_valid(ballot_valid), .yes_count(yes_count), .agreement(agreement),
        .result_pulse(result_pulse), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: raw inputs -> two-stage delay -> run-length debounce -> press events -> session rules.
    int       m_phase, m_timer, m_yes;
    bit [2:0] m_led, m_bal, w1, w2;
    bit       m_ag, m_to, m_rp;
    bit [3:0] sy1, sy2, lvl, rose, mpress;
    int       run [4];
    bit       model_ready = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_timer = 0; m_yes = 0;
            m_led = 0; m_bal = 0; m_ag = 0; m_to = 0; m_rp = 0;
            sy1 = 0; sy2 = 0; lvl = 0; rose = 0; mpress = 0; w1 = 0; w2 = 0;
            for (int i = 0; i < 4; i++) run[i] = 0;
            model_ready = 1'b1;
        end else begin
            m_rp = (m_phase == P_TALLY);
            case (m_phase)
                P_IDLE, P_SHOW: if (mpress[3]) begin
                    m_phase = P_OPEN; m_timer = WIN - 1;
                    m_led = 0; m_bal = 0; m_yes = 0; m_ag = 0; m_to = 0;
                end
                P_OPEN: begin
                    for (int i = 0; i < 3; i++)
                        if (mpress[i] && !m_led[i]) begin
                            m_led[i] = 1'b1;
                            m_bal[i] = w2[i];
                        end
                    if (m_led == 3'b111) begin m_phase = P_TALLY; m_to = 0; end
                    else if (m_timer == 0) begin m_phase = P_TALLY; m_to = 1; end
                    else m_timer = m_timer - 1;
                end
                P_TALLY: begin
                    m_yes = $countones(m_bal);
                    m_ag = (m_yes >= 2);
                    m_phase = P_SHOW;
                end
                default: m_phase = P_IDLE;
            endcase
            mpress = rose;
            rose = 0;
            for (int i = 0; i < 4; i++) begin
                if (sy2[i] != lvl[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == DB) begin
                        lvl[i] = sy2[i];
                        run[i] = 0;
                        rose[i] = lvl[i];
                    end
                end else begin
                    run[i] = 0;
                end
            end
            sy2 = sy1; sy1 = {start_btn, cast_btn};
            w2 = w1; w1 = sw_in;
        end
    end

    logic [12:0] exp_v, act_v;
    int open_cycles = 0;
    int pulses = 0;

    always @(negedge clk) begin
        if (model_ready) begin
            exp_v = {m_phase == P_OPEN, m_led, m_bal, m_phase == P_SHOW, 2'(m_yes), m_ag, m_rp, m_to};
            act_v = {window_open, cast_led, ballot, ballot_valid, yes_count, agreement, result_pulse, timeout};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_cycle t=%0t actual=%b required=%b", $time, act_v, exp_v);
            end
            checks++;
            if (window_open && ballot_valid) begin
                errors++;
                $display("FAIL open_and_valid t=%0t actual=1 required=0", $time);
            end
        end
        if (window_open) open_cycles++;
        if (result_pulse) pulses++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mask bit 3 = start, bits 2:0 = cast buttons
    task automatic press_btn(input bit [3:0] mask);
        @(negedge clk);
        start_btn = mask[3];
        cast_btn  = mask[2:0];
        cyc(8);
        start_btn = 1'b0;
        cast_btn  = '0;
        cyc(8);
    endtask

    task automatic wait_show(input string name, input int budget);
        int n = 0;
        while (!ballot_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, ballot_valid, 1);
    endtask

    function automatic int all_out();
        return int'({window_open, cast_led, ballot, ballot_valid, yes_count, agreement, result_pulse, timeout});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset, casts ignored in IDLE
        cyc(3);
        rst_n = 1'b1;
        chk("reset_outputs", all_out(), 0);
        press_btn(4'b0111);
        chk("idle_cast_led", cast_led, 0);
        chk("idle_window", window_open, 0);

        // 2: spaced casts, sw=101
        press_btn(4'b1000);
        chk("t2_open", window_open, 1);
        sw_in = 3'b101;
        press_btn(4'b0001);
        chk("t2_led_a", cast_led, 3'b001);
        press_btn(4'b0010);
        chk("t2_led_b", cast_led, 3'b011);
        @(negedge clk);
        cast_btn = 3'b100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!result_pulse && n < 30);
        chk("t2_pulse_latency", n, 9);
        cast_btn = '0;
        chk("t2_led_c", cast_led, 3'b111);
        chk("t2_ballot", ballot, 3'b101);
        chk("t2_yes", yes_count, 2);
        chk("t2_agree", agreement, 1);
        chk("t2_timeout", timeout, 0);
        cyc(8);

        // 3: timeout with one voter
        open_cycles = 0;
        sw_in = 3'b111;
        press_btn(4'b1000);
        press_btn(4'b0001);
        wait_show("t3_show", 200);
        chk("t3_window_len", open_cycles, WIN);
        chk("t3_timeout", timeout, 1);
        chk("t3_ballot", ballot, 3'b001);
        chk("t3_yes", yes_count, 1);
        chk("t3_agree", agreement, 0);

        // 4: bounce rejection and recast ignored
        press_btn(4'b1000);
        for (int k = 0; k < 3; k++) begin
            cast_btn = 3'b010;
            cyc(3);
            cast_btn = '0;
            cyc(3);
        end
        cyc(8);
        chk("t4_bounce_led", cast_led, 0);
        sw_in = 3'b010;
        press_btn(4'b0010);
        chk("t4_led", cast_led, 3'b010);
        sw_in = 3'b000;
        press_btn(4'b0010);
        chk("t4_recast_ballot", ballot, 3'b010);
        wait_show("t4_show", 200);
        chk("t4_timeout", timeout, 1);

        // 5: simultaneous casts, start ignored in OPEN
        press_btn(4'b1000);
        pulses = 0;
        press_btn(4'b1000);
        chk("t5_still_open", window_open, 1);
        sw_in = 3'b011;
        press_btn(4'b0111);
        wait_show("t5_show", 50);
        cyc(5);
        chk("t5_pulses", pulses, 1);
        chk("t5_ballot", ballot, 3'b011);
        chk("t5_yes", yes_count, 2);
        chk("t5_agree", agreement, 1);
        chk("t5_timeout", timeout, 0);

        // 6: reset mid-window
        press_btn(4'b1000);
        press_btn(4'b0001);
        press_btn(4'b0100);
        chk("t6_led_before", cast_led, 3'b101);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_reset_outputs", all_out(), 0);
        press_btn(4'b1000);
        chk("t6_open", window_open, 1);
        chk("t6_led", cast_led, 0);
        cyc(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
